// File: rtl/dvp_pixel_packer.sv
// DVP pixel packer: crops the incoming RGB565 stream to a window, pairs pixels
// into 32-bit words and queues them with frame markers in a fall-through FIFO.
module dvp_pixel_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int X_START    = 0,
  parameter int Y_START    = 0,
  parameter int CROP_W     = 16,
  parameter int CROP_H     = 12
) (
  input  logic        PCLK,
  input  logic        Rst_n,
  input  logic        DataValid,
  input  logic [15:0] DataPixel,
  input  logic        DataVs,
  input  logic [11:0] Xaddr,
  input  logic [11:0] Yaddr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        Overflow,
  output logic [7:0]  FrameCnt
);
  // state   | meaning
  // WAIT_VS | after reset, waiting for the first frame start
  // ACTIVE  | capturing and pairing pixels inside the crop window
  // DROP    | a word was lost; pixels ignored until the next frame start
  typedef enum logic [1:0] {WAIT_VS, ACTIVE, DROP} state_t;

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [11:0] X_LO    = 12'(X_START);
  localparam logic [11:0] Y_LO    = 12'(Y_START);
  localparam logic [11:0] W_C     = 12'(CROP_W);
  localparam logic [11:0] H_C     = 12'(CROP_H);
  localparam logic [11:0] X_LAST  = 12'(CROP_W - 1);
  localparam logic [11:0] Y_LAST  = 12'(CROP_H - 1);

  state_t          state_q, state_d;
  logic            vs_q;
  logic            phase_q;
  logic [15:0]     low_q;
  logic            sof_armed_q;
  logic [33:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            overflow_q;
  logic [7:0]      frame_cnt_q;

  logic            frame_start, in_win, pix_take, push, pop, push_ok, push_drop, push_eof;
  logic [11:0]     x_off, y_off;
  logic [33:0]     push_word, head;

  // Offsets wrap below the window start, so one unsigned compare covers both bounds.
  assign x_off       = Xaddr - X_LO;
  assign y_off       = Yaddr - Y_LO;
  assign frame_start = DataVs & ~vs_q;
  assign in_win      = (x_off < W_C) && (y_off < H_C);
  assign pix_take    = (state_q == ACTIVE) && !frame_start && DataValid && in_win;
  assign push        = pix_take && phase_q;
  assign pop         = (count_q != '0) && out_ready;
  assign push_ok     = push && ((count_q < DEPTH_C) || pop);
  assign push_drop   = push && !push_ok;
  assign push_eof    = (x_off == X_LAST) && (y_off == Y_LAST);
  assign push_word   = {DataPixel, low_q, sof_armed_q, push_eof};

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VS: if (frame_start) state_d = ACTIVE;
      ACTIVE:  if (frame_start) state_d = ACTIVE;
               else if (push_drop) state_d = DROP;
      DROP:    if (frame_start) state_d = ACTIVE;
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= WAIT_VS;
      vs_q        <= 1'b0;
      phase_q     <= 1'b0;
      low_q       <= '0;
      sof_armed_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= DataVs;
      if (frame_start) begin
        phase_q     <= 1'b0;
        sof_armed_q <= 1'b1;
      end else begin
        if (pix_take) begin
          phase_q <= ~phase_q;
          if (!phase_q) low_q <= DataPixel;
        end
        if (push_ok) sof_armed_q <= 1'b0;
      end
      if (push_drop) overflow_q <= 1'b1;
      if (push_ok && push_eof) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  // Outputs are gated by occupancy so reset forces them to zero without clearing storage.
  assign head      = mem[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head[33:2] : '0;
  assign out_sof   = out_valid & head[1];
  assign out_eof   = out_valid & head[0];
  assign Overflow  = overflow_q;
  assign FrameCnt  = frame_cnt_q;
endmodule
